// File: rtl/fabric_common_pkg.sv
// Error codes shared by the fabric switch blocks.
// All fabric modules report through these values so software decodes them in one place.
package fabric_common;

    localparam logic [15:0] CFG_TEMPORAL_SW_DUP_TAG       = 16'h0101;
    localparam logic [15:0] RT_TEMPORAL_SW_NO_MATCH       = 16'h0201;
    localparam logic [15:0] RT_TEMPORAL_SW_UNROUTED_INPUT = 16'h0202;

endpackage

// File: rtl/fabric_temporal_sw_arb_pkg.sv
// Local types for the temporal switch: error classification and its mapping
// onto the shared fabric error codes.
package fabric_temporal_sw_arb_pkg;

    import fabric_common::*;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_UNROUTED,
        ERR_NO_MATCH,
        ERR_DUP_TAG
    } err_kind_e;

    // Highest-severity condition wins when several appear in the same cycle.
    function automatic err_kind_e err_pick(input logic dup_tag,
                                           input logic no_match,
                                           input logic unrouted);
        if (dup_tag) begin
            return ERR_DUP_TAG;
        end
        if (no_match) begin
            return ERR_NO_MATCH;
        end
        if (unrouted) begin
            return ERR_UNROUTED;
        end
        return ERR_NONE;
    endfunction

    function automatic logic [15:0] err_code_of(input err_kind_e kind);
        case (kind)
            ERR_DUP_TAG:  return CFG_TEMPORAL_SW_DUP_TAG;
            ERR_NO_MATCH: return RT_TEMPORAL_SW_NO_MATCH;
            ERR_UNROUTED: return RT_TEMPORAL_SW_UNROUTED_INPUT;
            default:      return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/fabric_rr_arb.sv
// One-hot arbiter: round-robin from a rotating pointer, or fixed priority
// (lowest index) when FIXED_PRIO is set.
module fabric_rr_arb #(
    parameter int NUM_REQ    = 2,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic [PTR_W-1:0]   start;
    logic [NUM_REQ-1:0] req_hi;
    logic [NUM_REQ-1:0] gnt_hi;
    logic [NUM_REQ-1:0] gnt_lo;

    assign start = FIXED_PRIO ? '0 : rr_ptr;

    always_comb begin
        req_hi = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_hi[i] = req[i] && (i >= int'(start));
        end
    end

    // Lowest set bit at/above the pointer, else lowest set bit overall.
    always_comb begin
        gnt_hi = '0;
        gnt_lo = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_hi[i]) begin
                gnt_hi    = '0;
                gnt_hi[i] = 1'b1;
            end
            if (req[i]) begin
                gnt_lo    = '0;
                gnt_lo[i] = 1'b1;
            end
        end
    end

    assign gnt = (|req_hi) ? gnt_hi : gnt_lo;

    always_comb begin
        ptr_next = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                ptr_next = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/fabric_temporal_sw_arb.sv
// Tag-routed switch: each input is matched against a route table and forwarded
// (unicast or multicast with partial progress) into one-entry output slots.
module fabric_temporal_sw_arb
    import fabric_temporal_sw_arb_pkg::*;
#(
    parameter int NUM_INPUTS      = 2,
    parameter int NUM_OUTPUTS     = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int TAG_WIDTH       = 4,
    parameter int NUM_ROUTE_TABLE = 4,
    parameter logic [NUM_OUTPUTS*NUM_INPUTS-1:0] CONNECTIVITY = '1,
    parameter int ARB_MODE        = 1
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [NUM_INPUTS-1:0]                           in_valid,
    output logic [NUM_INPUTS-1:0]                           in_ready,
    input  logic [NUM_INPUTS*(DATA_WIDTH+TAG_WIDTH)-1:0]    in_data,
    output logic [NUM_OUTPUTS-1:0]                          out_valid,
    input  logic [NUM_OUTPUTS-1:0]                          out_ready,
    output logic [NUM_OUTPUTS*(DATA_WIDTH+TAG_WIDTH)-1:0]   out_data,
    input  logic [NUM_ROUTE_TABLE*(1+TAG_WIDTH+NUM_OUTPUTS)-1:0] cfg_data,
    output logic                                            error_valid,
    output logic [15:0]                                     error_code
);

    localparam int PW = DATA_WIDTH + TAG_WIDTH;
    localparam int EW = 1 + TAG_WIDTH + NUM_OUTPUTS;

    if (NUM_INPUTS < 1) begin : g_bad_num_inputs
        $fatal(1, "fabric_temporal_sw_arb: NUM_INPUTS must be >= 1");
    end
    if (NUM_OUTPUTS < 1) begin : g_bad_num_outputs
        $fatal(1, "fabric_temporal_sw_arb: NUM_OUTPUTS must be >= 1");
    end
    if (TAG_WIDTH < 1) begin : g_bad_tag_width
        $fatal(1, "fabric_temporal_sw_arb: TAG_WIDTH must be >= 1");
    end
    if (NUM_ROUTE_TABLE < 1) begin : g_bad_route_table
        $fatal(1, "fabric_temporal_sw_arb: NUM_ROUTE_TABLE must be >= 1");
    end
    if (ARB_MODE != 0 && ARB_MODE != 1) begin : g_bad_arb_mode
        $fatal(1, "fabric_temporal_sw_arb: ARB_MODE must be 0 or 1");
    end

    logic [NUM_ROUTE_TABLE-1:0] ent_valid;
    logic [TAG_WIDTH-1:0]       ent_tag    [NUM_ROUTE_TABLE];
    logic [NUM_OUTPUTS-1:0]     ent_routes [NUM_ROUTE_TABLE];

    for (genvar e = 0; e < NUM_ROUTE_TABLE; e++) begin : g_ent
        assign ent_valid[e]  = cfg_data[e*EW + EW - 1];
        assign ent_tag[e]    = cfg_data[e*EW + NUM_OUTPUTS +: TAG_WIDTH];
        assign ent_routes[e] = cfg_data[e*EW +: NUM_OUTPUTS];
    end

    logic [NUM_INPUTS-1:0]                  matched;
    logic [NUM_INPUTS-1:0]                  routed;
    logic [NUM_INPUTS-1:0]                  done;
    logic [NUM_INPUTS-1:0][NUM_OUTPUTS-1:0] eff;
    logic [NUM_INPUTS-1:0][NUM_OUTPUTS-1:0] served;
    logic [NUM_INPUTS-1:0][NUM_OUTPUTS-1:0] granted;
    logic [NUM_INPUTS-1:0][NUM_OUTPUTS-1:0] outstanding;
    logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0] gnt_all;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
        logic [TAG_WIDTH-1:0]   tag;
        logic [NUM_OUTPUTS-1:0] conn_col;
        logic [NUM_OUTPUTS-1:0] hit_routes;
        logic                   hit;

        assign tag = in_data[i*PW + DATA_WIDTH +: TAG_WIDTH];

        for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_conn
            assign conn_col[o]   = CONNECTIVITY[o*NUM_INPUTS + i];
            assign granted[i][o] = gnt_all[o][i];
        end

        // Later entries overwrite earlier ones, so the highest index match wins.
        always_comb begin
            hit        = 1'b0;
            hit_routes = '0;
            for (int e = 0; e < NUM_ROUTE_TABLE; e++) begin
                if (ent_valid[e] && (ent_tag[e] == tag)) begin
                    hit        = 1'b1;
                    hit_routes = ent_routes[e];
                end
            end
        end

        assign matched[i]     = hit;
        assign eff[i]         = hit_routes & conn_col;
        assign routed[i]      = |eff[i];
        assign outstanding[i] = eff[i] & ~served[i];
        // Word retires in the cycle its last outstanding target is granted.
        assign done[i] = in_valid[i] & matched[i] & (|outstanding[i])
                       & ((outstanding[i] & ~granted[i]) == '0);
    end

    assign in_ready = done & {NUM_INPUTS{rst_n}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            served <= '0;
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                served[i] <= done[i] ? '0 : (served[i] | granted[i]);
            end
        end
    end

    for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_out
        logic [NUM_INPUTS-1:0] req;
        logic                  slot_free;
        logic                  valid_q;
        logic [PW-1:0]         data_q;
        logic [PW-1:0]         win_data;

        assign slot_free = !valid_q | out_ready[o];

        for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_req
            assign req[i] = in_valid[i] & matched[i] & eff[i][o] & ~served[i][o] & slot_free;
        end

        fabric_rr_arb #(
            .NUM_REQ    (NUM_INPUTS),
            .FIXED_PRIO (ARB_MODE == 0)
        ) u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (req),
            .gnt   (gnt_all[o])
        );

        always_comb begin
            win_data = '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (gnt_all[o][i]) begin
                    win_data = in_data[i*PW +: PW];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (|gnt_all[o]) begin
                valid_q <= 1'b1;
                data_q  <= win_data;
            end else if (out_ready[o]) begin
                valid_q <= 1'b0;
            end
        end

        assign out_valid[o]            = valid_q;
        assign out_data[o*PW +: PW]    = data_q;
    end

    logic      dup_tag;
    logic      no_match;
    logic      unrouted;
    err_kind_e err_kind;

    always_comb begin
        dup_tag = 1'b0;
        for (int e = 0; e < NUM_ROUTE_TABLE; e++) begin
            for (int f = e + 1; f < NUM_ROUTE_TABLE; f++) begin
                if (ent_valid[e] && ent_valid[f] && (ent_tag[e] == ent_tag[f])) begin
                    dup_tag = 1'b1;
                end
            end
        end
    end

    assign no_match = |(in_valid & ~matched);
    assign unrouted = |(in_valid & matched & ~routed);
    assign err_kind = err_pick(dup_tag, no_match, unrouted);

    // Only the first error is kept; the datapath keeps running regardless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_valid <= 1'b0;
            error_code  <= 16'h0000;
        end else if (!error_valid && (err_kind != ERR_NONE)) begin
            error_valid <= 1'b1;
            error_code  <= err_code_of(err_kind);
        end
    end

endmodule

// File: tb/tb_fabric_temporal_sw_arb.sv
// Bench for fabric_temporal_sw_arb: a reference model tracks the default
// instance every cycle; directed scenarios pin literal expectations.
module tb_fabric_temporal_sw_arb;

    import fabric_common::*;

    localparam int NI  = 2;
    localparam int NO  = 2;
    localparam int DW  = 32;
    localparam int TW  = 4;
    localparam int NRT = 4;
    localparam int PW  = DW + TW;
    localparam int EW  = 1 + TW + NO;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]     a_in_valid = '0, a_in_ready;
    logic [NI*PW-1:0]  a_in_data = '0;
    logic [NO-1:0]     a_out_valid, a_out_ready = '1;
    logic [NO*PW-1:0]  a_out_data;
    logic [NRT*EW-1:0] a_cfg = '0;
    logic              a_error_valid;
    logic [15:0]       a_error_code;

    logic [NI-1:0]     b_in_valid = '0, b_in_ready;
    logic [NI*PW-1:0]  b_in_data = '0;
    logic [NO-1:0]     b_out_valid, b_out_ready = '1;
    logic [NO*PW-1:0]  b_out_data;
    logic [NRT*EW-1:0] b_cfg = '0;
    logic              b_error_valid;
    logic [15:0]       b_error_code;

    fabric_temporal_sw_arb dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .cfg_data(a_cfg), .error_valid(a_error_valid), .error_code(a_error_code)
    );

    // Input 1 may not reach output 0; fixed priority arbitration.
    fabric_temporal_sw_arb #(.CONNECTIVITY(4'b1101), .ARB_MODE(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .cfg_data(b_cfg), .error_valid(b_error_valid), .error_code(b_error_code)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] ent(input int v, input int tag, input int routes);
        return {v[0], tag[TW-1:0], routes[NO-1:0]};
    endfunction

    function automatic logic [PW-1:0] word(input int tag, input logic [DW-1:0] d);
        return {tag[TW-1:0], d};
    endfunction

    // Reference model state for dut_a (round-robin, full connectivity).
    bit            m_ov[NO], n_ov[NO];
    logic [PW-1:0] m_od[NO], n_od[NO];
    int            m_srv[NI], n_srv[NI];
    int            m_rr[NO], n_rr[NO];
    bit            m_ev, n_ev;
    logic [15:0]   m_ec, n_ec;
    logic [NI-1:0] m_rdy;

    task automatic model_reset();
        for (int o = 0; o < NO; o++) begin
            m_ov[o] = 0; m_od[o] = '0; m_rr[o] = 0;
        end
        for (int i = 0; i < NI; i++) m_srv[i] = 0;
        m_ev = 0; m_ec = '0; m_rdy = '0;
    endtask

    task automatic model_eval();
        int mt[NI], rt[NI], newly[NI], gi[NO];
        int tag, idx, pend;
        logic [EW-1:0] en;
        bit dup, nm, ur;
        dup = 0; nm = 0; ur = 0;
        for (int i = 0; i < NI; i++) begin
            tag = int'(a_in_data[i*PW + DW +: TW]);
            mt[i] = 0; rt[i] = 0;
            for (int e = 0; e < NRT; e++) begin
                en = a_cfg[e*EW +: EW];
                if (en[EW-1] && int'(en[NO +: TW]) == tag) begin
                    mt[i] = 1; rt[i] = int'(en[NO-1:0]);
                end
            end
            if (a_in_valid[i] && mt[i] == 0) nm = 1;
            if (a_in_valid[i] && mt[i] == 1 && rt[i] == 0) ur = 1;
        end
        for (int e = 0; e < NRT; e++)
            for (int f = e + 1; f < NRT; f++)
                if (a_cfg[e*EW + EW - 1] && a_cfg[f*EW + EW - 1] &&
                    a_cfg[e*EW + NO +: TW] == a_cfg[f*EW + NO +: TW]) dup = 1;
        for (int o = 0; o < NO; o++) begin
            gi[o] = -1;
            if (!m_ov[o] || a_out_ready[o]) begin
                for (int k = 0; k < NI; k++) begin
                    idx = (m_rr[o] + k) % NI;
                    if (gi[o] < 0 && a_in_valid[idx] && mt[idx] == 1 &&
                        ((rt[idx] >> o) & 1) == 1 && ((m_srv[idx] >> o) & 1) == 0) gi[o] = idx;
                end
            end
            n_ov[o] = (gi[o] >= 0) ? 1'b1 : (a_out_ready[o] ? 1'b0 : m_ov[o]);
            n_od[o] = (gi[o] >= 0) ? a_in_data[gi[o]*PW +: PW] : m_od[o];
            n_rr[o] = (gi[o] >= 0) ? (gi[o] + 1) % NI : m_rr[o];
        end
        for (int i = 0; i < NI; i++) begin
            newly[i] = 0;
            for (int o = 0; o < NO; o++) if (gi[o] == i) newly[i] |= (1 << o);
            pend = rt[i] & ~m_srv[i];
            m_rdy[i] = a_in_valid[i] && mt[i] == 1 && pend != 0 && (pend & ~newly[i]) == 0;
            n_srv[i] = m_rdy[i] ? 0 : (m_srv[i] | newly[i]);
        end
        n_ev = m_ev; n_ec = m_ec;
        if (!m_ev && (dup || nm || ur)) begin
            n_ev = 1;
            n_ec = dup ? CFG_TEMPORAL_SW_DUP_TAG : (nm ? RT_TEMPORAL_SW_NO_MATCH
                                                       : RT_TEMPORAL_SW_UNROUTED_INPUT);
        end
    endtask

    task automatic model_commit();
        for (int o = 0; o < NO; o++) begin
            m_ov[o] = n_ov[o]; m_od[o] = n_od[o]; m_rr[o] = n_rr[o];
        end
        for (int i = 0; i < NI; i++) m_srv[i] = n_srv[i];
        m_ev = n_ev; m_ec = n_ec;
    endtask

    // Per-cycle compare of dut_a against the model.
    initial begin
        logic [NO-1:0]    ev;
        logic [NO*PW-1:0] ed;
        model_reset();
        forever begin
            @(negedge clk);
            for (int o = 0; o < NO; o++) begin
                ev[o] = m_ov[o]; ed[o*PW +: PW] = m_od[o];
            end
            chk("model_out_valid", a_out_valid, ev);
            chk("model_out_data", a_out_data, ed);
            chk("model_error_valid", a_error_valid, m_ev);
            chk("model_error_code", a_error_code, m_ec);
            #4;
            if (!rst_n) begin
                model_reset();
                chk("model_in_ready_rst", a_in_ready, '0);
            end else begin
                model_eval();
                chk("model_in_ready", a_in_ready, m_rdy);
            end
            @(posedge clk);
            if (rst_n) model_commit();
            else model_reset();
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        nxt();
        rst_n = 1'b0;
        a_in_valid = '0; b_in_valid = '0;
        a_out_ready = '1; b_out_ready = '1;
        #1;
        chk("rst_out_valid", a_out_valid, '0);
        chk("rst_in_ready", a_in_ready, '0);
        nxt();
        chk("rst_out_data", a_out_data, '0);
        chk("rst_error_valid", a_error_valid, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d0, d1;
        logic [NI-1:0] exp_rdy;
        logic [NI-1:0] pending, acc;
        logic [PW-1:0] pw[NI];
        int            ptag[NI];
        int            r;

        // Unicast
        do_reset();
        a_cfg = {ent(0, 0, 0), ent(0, 0, 0), ent(0, 0, 0), ent(1, 3, 2'b01)};
        a_in_valid = 2'b01;
        a_in_data = {word(0, '0), word(3, 32'hAA)};
        #2 chk("uni_in_ready", a_in_ready, 2'b01);
        nxt();
        chk("uni_out_valid", a_out_valid, 2'b01);
        chk("uni_out_data", a_out_data[PW-1:0], word(3, 32'hAA));
        chk("uni_no_error", a_error_valid, 1'b0);
        a_in_valid = '0;

        // Two inputs contending for output 0
        do_reset();
        d0 = 32'h100; d1 = 32'h200;
        a_in_valid = 2'b11;
        a_in_data = {word(3, d1), word(3, d0)};
        for (int k = 0; k < 4; k++) begin
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            #2 chk("rr_in_ready", a_in_ready, exp_rdy);
            nxt();
            chk("rr_out_data", a_out_data[PW-1:0], (k % 2 == 0) ? word(3, d0) : word(3, d1));
            if (k % 2 == 0) d0++; else d1++;
            a_in_data = {word(3, d1), word(3, d0)};
        end
        a_in_valid = '0;

        // Multicast with output 1 blocked
        do_reset();
        a_cfg = {ent(0, 0, 0), ent(0, 0, 0), ent(1, 4, 2'b10), ent(1, 3, 2'b11)};
        a_out_ready = 2'b01;
        a_in_valid = 2'b10;
        a_in_data = {word(4, 32'h41), word(3, 32'hC0)};
        #2 chk("mc_fill_ready", a_in_ready, 2'b10);
        nxt();
        chk("mc_fill_valid", a_out_valid, 2'b10);
        a_in_valid = 2'b01;
        #2 chk("mc_partial_ready", a_in_ready, 2'b00);
        nxt();
        chk("mc_partial_valid", a_out_valid, 2'b11);
        chk("mc_partial_data", a_out_data[PW-1:0], word(3, 32'hC0));
        #2 chk("mc_hold_ready", a_in_ready, 2'b00);
        nxt();
        chk("mc_no_dup", a_out_valid, 2'b10);
        a_out_ready = 2'b11;
        #2 chk("mc_final_ready", a_in_ready, 2'b01);
        nxt();
        chk("mc_final_valid", a_out_valid, 2'b10);
        chk("mc_final_data", a_out_data[2*PW-1:PW], word(3, 32'hC0));
        a_in_valid = '0;

        // Reset in the middle of a multicast
        do_reset();
        a_out_ready = 2'b01;
        a_in_valid = 2'b10;
        a_in_data = {word(4, 32'h42), word(3, 32'hD0)};
        nxt();
        a_in_valid = 2'b01;
        nxt();
        chk("rstmc_partial_valid", a_out_valid, 2'b11);
        rst_n = 1'b0;
        a_out_ready = 2'b11;
        #1;
        chk("rstmc_out_valid", a_out_valid, 2'b00);
        chk("rstmc_in_ready", a_in_ready, 2'b00);
        nxt();
        rst_n = 1'b1;
        #2 chk("rstmc_resend_ready", a_in_ready, 2'b01);
        nxt();
        chk("rstmc_resend_valid", a_out_valid, 2'b11);
        chk("rstmc_resend_data", a_out_data, {word(3, 32'hD0), word(3, 32'hD0)});
        a_in_valid = '0;

        // Duplicate tags in the route table
        do_reset();
        a_cfg = {ent(0, 0, 0), ent(1, 5, 2'b01), ent(0, 0, 0), ent(1, 5, 2'b01)};
        nxt();
        chk("dup_error_valid", a_error_valid, 1'b1);
        chk("dup_error_code", a_error_code, CFG_TEMPORAL_SW_DUP_TAG);
        a_in_valid = 2'b01;
        a_in_data = {word(0, '0), word(9, 32'h1)};
        nxt();
        nxt();
        chk("dup_held", a_error_code, CFG_TEMPORAL_SW_DUP_TAG);
        a_in_valid = '0;

        // Simultaneous unrouted and unmatched inputs
        do_reset();
        a_cfg = {ent(0, 0, 0), ent(0, 0, 0), ent(0, 0, 0), ent(1, 8, 2'b00)};
        a_in_valid = 2'b11;
        a_in_data = {word(9, 32'h2), word(8, 32'h3)};
        #2 chk("nm_in_ready", a_in_ready, 2'b00);
        nxt();
        chk("nm_error_code", a_error_code, RT_TEMPORAL_SW_NO_MATCH);
        a_in_valid = '0;

        // Unrouted by connectivity on dut_b
        do_reset();
        b_cfg = {ent(0, 0, 0), ent(0, 0, 0), ent(0, 0, 0), ent(1, 6, 2'b01)};
        b_in_valid = 2'b10;
        b_in_data = {word(6, 32'h66), word(0, '0)};
        for (int k = 0; k < 3; k++) begin
            #2 chk("unr_in_ready", b_in_ready, 2'b00);
            nxt();
        end
        chk("unr_error_valid", b_error_valid, 1'b1);
        chk("unr_error_code", b_error_code, RT_TEMPORAL_SW_UNROUTED_INPUT);
        chk("unr_out_valid", b_out_valid, 2'b00);

        // Fixed priority on dut_b
        do_reset();
        b_cfg = {ent(0, 0, 0), ent(0, 0, 0), ent(0, 0, 0), ent(1, 7, 2'b10)};
        d0 = 32'h700;
        b_in_valid = 2'b11;
        b_in_data = {word(7, 32'h7FF), word(7, d0)};
        for (int k = 0; k < 2; k++) begin
            #2 chk("fp_in_ready", b_in_ready, 2'b01);
            nxt();
            chk("fp_out_data", b_out_data[2*PW-1:PW], word(7, d0));
            d0++;
            b_in_data = {word(7, 32'h7FF), word(7, d0)};
        end
        b_in_valid = '0;

        // Randomized traffic against the model
        do_reset();
        a_cfg = {ent(1, 8, 2'b00), ent(1, 3, 2'b11), ent(1, 2, 2'b10), ent(1, 1, 2'b01)};
        pending = '0; acc = '0;
        for (int i = 0; i < NI; i++) begin
            pw[i] = '0; ptag[i] = 0;
        end
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < NI; i++) begin
                if (pending[i] && acc[i]) pending[i] = 1'b0;
                if (pending[i] && (ptag[i] >= 8) && ($urandom % 2 == 0)) pending[i] = 1'b0;
                if (!pending[i] && ($urandom % 4 != 0)) begin
                    r = int'($urandom % 10);
                    ptag[i] = (r == 0) ? 9 : ((r == 1) ? 8 : 1 + (r % 3));
                    pw[i] = word(ptag[i], $urandom);
                    pending[i] = 1'b1;
                end
                a_in_data[i*PW +: PW] = pw[i];
            end
            a_in_valid = pending;
            a_out_ready = NO'($urandom % 4);
            #2 acc = a_in_ready;
            nxt();
        end
        a_in_valid = '0;
        nxt();
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
